dram_6sig_burst_seq: RTL and testbench

Per-byte-lane burst sequencer for the DDR 6-signal pad group (4 DQ, 1 DQS, 1 async). It accepts read and write commands over a valid/ready handshake and sequences the pad controls through preamble, burst and postamble at the programmed latency: drive enable, DQS toggle data, pad enable, DQS read window, and the pos/neg capture pointers. It sits in the DRAM controller clock domain between the channel scheduler and the pad macro.

---
 rtl/dram_6sig_burst_seq_if.sv | 55 +++++
 rtl/dram_6sig_burst_seq.sv | 138 +++++++++++++
 tb/tb_dram_6sig_burst_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_6sig_burst_seq_if.sv
// Command handshake, latency config and pad-control bundle
// between the channel scheduler and the byte-lane sequencer.
interface dram_6sig_burst_seq_if;
  logic [2:0] cfg_cas_lat;
  logic [2:0] cfg_wr_lat;
  logic       burst_length_four;
  logic       cmd_valid;
  logic       cmd_rd;
  logic       cmd_ready;
  logic       dram_io_drive_enable;
  logic       dram_io_drive_data;
  logic       dram_io_pad_enable;
  logic       dqs_read;
  logic [1:0] pad_pos_cnt;
  logic [1:0] pad_neg_cnt;
  logic       wr_data_req;
  logic       rd_data_vld;
  logic       busy;

  modport master (
    output cfg_cas_lat,
    output cfg_wr_lat,
    output burst_length_four,
    output cmd_valid,
    output cmd_rd,
    input  cmd_ready,
    input  dram_io_drive_enable,
    input  dram_io_drive_data,
    input  dram_io_pad_enable,
    input  dqs_read,
    input  pad_pos_cnt,
    input  pad_neg_cnt,
    input  wr_data_req,
    input  rd_data_vld,
    input  busy
  );

  modport slave (
    input  cfg_cas_lat,
    input  cfg_wr_lat,
    input  burst_length_four,
    input  cmd_valid,
    input  cmd_rd,
    output cmd_ready,
    output dram_io_drive_enable,
    output dram_io_drive_data,
    output dram_io_pad_enable,
    output dqs_read,
    output pad_pos_cnt,
    output pad_neg_cnt,
    output wr_data_req,
    output rd_data_vld,
    output busy
  );
endinterface

// File: rtl/dram_6sig_burst_seq.sv
// Per-byte-lane DDR burst sequencer: preamble, burst and
// postamble pad controls at the latched, clamped latency.
module dram_6sig_burst_seq #(
  parameter int CL_MIN     = 2,
  parameter int WL_MIN     = 1,
  parameter int RD_VLD_DLY = 2
) (
  input logic                  rclk,
  input logic                  rst,
  dram_6sig_burst_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PRE,
    BURST,
    POST
  } state_e;

  localparam logic [2:0] CL_MIN_W = 3'(CL_MIN);
  localparam logic [2:0] WL_MIN_W = 3'(WL_MIN);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rd_q, rd_d;
  logic       bl4_q, bl4_d;
  logic [1:0] pos_q, neg_q;
  logic [RD_VLD_DLY-1:0] vld_q;
  logic [RD_VLD_DLY:0]   vld_sh;

  logic [2:0] cas_lat;
  logic [2:0] wr_lat;
  logic [2:0] lat;
  logic       de, dd, wrq, pe, dqs;

  assign cas_lat = (bus.cfg_cas_lat < CL_MIN_W)
                 ? CL_MIN_W : bus.cfg_cas_lat;
  assign wr_lat  = (bus.cfg_wr_lat < WL_MIN_W)
                 ? WL_MIN_W : bus.cfg_wr_lat;
  assign lat     = bus.cmd_rd ? cas_lat : wr_lat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    bl4_d   = bl4_q;
    de      = 1'b0;
    dd      = 1'b0;
    wrq     = 1'b0;
    pe      = 1'b0;
    dqs     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          rd_d  = bus.cmd_rd;
          bl4_d = bus.burst_length_four;
          if (lat > 3'd1) begin
            state_d = WAIT;
            cnt_d   = lat - 3'd2;
          end else begin
            state_d = PRE;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = PRE;
        else cnt_d = cnt_q - 3'd1;
      end
      PRE: begin
        state_d = BURST;
        cnt_d   = bl4_q ? 3'd1 : 3'd3;
        de      = ~rd_q;
        wrq     = ~rd_q;
        pe      = rd_q;
      end
      BURST: begin
        de  = ~rd_q;
        dd  = ~rd_q;
        // last burst cycle has no beat-pair left to fetch
        wrq = ~rd_q & (cnt_q != 3'd0);
        pe  = rd_q;
        dqs = rd_q;
        if (cnt_q == 3'd0) state_d = POST;
        else cnt_d = cnt_q - 3'd1;
      end
      POST: begin
        state_d = IDLE;
        de      = ~rd_q;
        pe      = rd_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      bl4_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      bl4_q   <= bl4_d;
    end
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      pos_q <= '0;
      neg_q <= '0;
    end else if (dqs) begin
      pos_q <= pos_q + 2'd1;
      neg_q <= pos_q;
    end
  end

  assign vld_sh = {vld_q, dqs};

  always_ff @(posedge rclk) begin
    if (rst) vld_q <= '0;
    else vld_q <= vld_sh[RD_VLD_DLY-1:0];
  end

  assign bus.cmd_ready            = (state_q == IDLE);
  assign bus.busy                 = (state_q != IDLE);
  assign bus.dram_io_drive_enable = de;
  assign bus.dram_io_drive_data   = dd;
  assign bus.dram_io_pad_enable   = pe;
  assign bus.dqs_read             = dqs;
  assign bus.wr_data_req          = wrq;
  assign bus.pad_pos_cnt          = pos_q;
  assign bus.pad_neg_cnt          = neg_q;
  assign bus.rd_data_vld          = vld_q[RD_VLD_DLY-1];

endmodule

// File: tb/tb_dram_6sig_burst_seq.sv
// Directed bench for the byte-lane burst sequencer: reset,
// write/read timing, latency clamp, back-to-back and abort.
module tb_dram_6sig_burst_seq;

  logic rclk;
  logic rst;
  int   checks;
  int   failures;
  logic [1:0] mpos;
  logic [1:0] mneg;

  dram_6sig_burst_seq_if bus ();

  dram_6sig_burst_seq dut (
    .rclk (rclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // {busy,ready,de,dd,wrq,pe,dqs_read,rd_vld} in cycle T+k
  function automatic logic [7:0] exp_vec(
    input bit rd, input int L, input int N, input int k
  );
    logic rdy, de, dd, wq, pe, dq, vl;
    rdy = (k >= L + N + 2);
    de  = !rd && k >= L     && k <= L + N + 1;
    dd  = !rd && k >= L + 1 && k <= L + N;
    wq  = !rd && k >= L     && k <= L + N - 1;
    pe  =  rd && k >= L     && k <= L + N + 1;
    dq  =  rd && k >= L + 1 && k <= L + N;
    vl  =  rd && k >= L + 3 && k <= L + N + 2;
    return {!rdy, rdy, de, dd, wq, pe, dq, vl};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {bus.busy, bus.cmd_ready,
            bus.dram_io_drive_enable,
            bus.dram_io_drive_data,
            bus.wr_data_req,
            bus.dram_io_pad_enable,
            bus.dqs_read,
            bus.rd_data_vld};
  endfunction

  task automatic test_reset();
    logic [7:0] o;
    @(negedge rclk);
    @(negedge rclk);
    rst = 1'b0;
    o = obs_vec();
    checks++;
    if (o !== 8'b0100_0000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", o, 8'b0100_0000);
    end
    checks++;
    if ({bus.pad_pos_cnt, bus.pad_neg_cnt} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ptr got=%b exp=0000",
               {bus.pad_pos_cnt, bus.pad_neg_cnt});
    end
    bus.cfg_cas_lat = 3'd2;
    bus.burst_length_four = 1'b0;
    bus.cmd_rd = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge rclk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge rclk);
    rst = 1'b1;
    repeat (1) @(negedge rclk);
    o = obs_vec();
    checks++;
    if (o !== 8'b0100_0000) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=%b", o, 8'b0100_0000);
    end
    checks++;
    if ({bus.pad_pos_cnt, bus.pad_neg_cnt} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_ptr got=%b exp=0000",
               {bus.pad_pos_cnt, bus.pad_neg_cnt});
    end
    bus.cmd_valid = 1'b1;
    @(negedge rclk);
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      o = obs_vec();
      checks++;
      if (o !== 8'b0100_0000) begin
        failures++;
        $display("FAIL rst_vs_valid i=%0d got=%b exp=%b",
                 i, o, 8'b0100_0000);
      end
      @(negedge rclk);
    end
    mpos = 2'd0;
    mneg = 2'd0;
  endtask

  task automatic test_write_wl1();
    logic [7:0] o, e;
    int L, N;
    L = 1;
    N = 2;
    bus.cfg_wr_lat = 3'd1;
    bus.burst_length_four = 1'b1;
    bus.cmd_rd = 1'b0;
    bus.cmd_valid = 1'b1;
    @(negedge rclk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= L + N + 2; k++) begin
      e = exp_vec(1'b0, L, N, k);
      o = obs_vec();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wr_wl1 k=%0d got=%b exp=%b", k, o, e);
      end
      checks++;
      if ({bus.pad_pos_cnt, bus.pad_neg_cnt} !== {mpos, mneg}) begin
        failures++;
        $display("FAIL wr_wl1_ptr k=%0d got=%b exp=%b", k,
                 {bus.pad_pos_cnt, bus.pad_neg_cnt}, {mpos, mneg});
      end
      if (k < L + N + 2) @(negedge rclk);
    end
  endtask

  task automatic test_read_cl3();
    logic [7:0] o, e;
    int L, N;
    L = 3;
    N = 4;
    bus.cfg_cas_lat = 3'd3;
    bus.burst_length_four = 1'b0;
    bus.cmd_rd = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge rclk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= L + N + 2; k++) begin
      e = exp_vec(1'b1, L, N, k);
      o = obs_vec();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rd_cl3 k=%0d got=%b exp=%b", k, o, e);
      end
      checks++;
      if ({bus.pad_pos_cnt, bus.pad_neg_cnt} !== {mpos, mneg}) begin
        failures++;
        $display("FAIL rd_cl3_ptr k=%0d got=%b exp=%b", k,
                 {bus.pad_pos_cnt, bus.pad_neg_cnt}, {mpos, mneg});
      end
      if (e[1]) begin
        mneg = mpos;
        mpos = mpos + 2'd1;
      end
      if (k < L + N + 2) @(negedge rclk);
    end
  endtask

  task automatic test_clamp();
    logic [7:0] o, e;
    int L, N;
    L = 2;
    N = 2;
    bus.cfg_cas_lat = 3'd0;
    bus.burst_length_four = 1'b1;
    bus.cmd_rd = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge rclk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= L + N + 2; k++) begin
      e = exp_vec(1'b1, L, N, k);
      o = obs_vec();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL clamp_cl0 k=%0d got=%b exp=%b", k, o, e);
      end
      checks++;
      if ({bus.pad_pos_cnt, bus.pad_neg_cnt} !== {mpos, mneg}) begin
        failures++;
        $display("FAIL clamp_cl0_ptr k=%0d got=%b exp=%b", k,
                 {bus.pad_pos_cnt, bus.pad_neg_cnt}, {mpos, mneg});
      end
      if (e[1]) begin
        mneg = mpos;
        mpos = mpos + 2'd1;
      end
      if (k < L + N + 2) @(negedge rclk);
    end
    L = 4;
    bus.cfg_cas_lat = 3'd4;
    bus.cmd_valid = 1'b1;
    @(negedge rclk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= L + N + 2; k++) begin
      if (k == 1) bus.cfg_cas_lat = 3'd7;
      e = exp_vec(1'b1, L, N, k);
      o = obs_vec();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL cfg_midwait k=%0d got=%b exp=%b", k, o, e);
      end
      checks++;
      if ({bus.pad_pos_cnt, bus.pad_neg_cnt} !== {mpos, mneg}) begin
        failures++;
        $display("FAIL cfg_midwait_ptr k=%0d got=%b exp=%b", k,
                 {bus.pad_pos_cnt, bus.pad_neg_cnt}, {mpos, mneg});
      end
      if (e[1]) begin
        mneg = mpos;
        mpos = mpos + 2'd1;
      end
      if (k < L + N + 2) @(negedge rclk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] o, e;
    int L, N;
    L = 1;
    N = 2;
    bus.cfg_wr_lat = 3'd0;
    bus.burst_length_four = 1'b1;
    bus.cmd_rd = 1'b0;
    bus.cmd_valid = 1'b1;
    @(negedge rclk);
    bus.cmd_rd = 1'b1;
    bus.cfg_cas_lat = 3'd2;
    for (int k = 1; k <= L + N + 2; k++) begin
      e = exp_vec(1'b0, L, N, k);
      o = obs_vec();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_wr k=%0d got=%b exp=%b", k, o, e);
      end
      if (k < L + N + 2) @(negedge rclk);
    end
    @(negedge rclk);
    bus.cmd_valid = 1'b0;
    L = 2;
    for (int k = 1; k <= L + N + 2; k++) begin
      e = exp_vec(1'b1, L, N, k);
      o = obs_vec();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_rd k=%0d got=%b exp=%b", k, o, e);
      end
      checks++;
      if ({bus.pad_pos_cnt, bus.pad_neg_cnt} !== {mpos, mneg}) begin
        failures++;
        $display("FAIL b2b_rd_ptr k=%0d got=%b exp=%b", k,
                 {bus.pad_pos_cnt, bus.pad_neg_cnt}, {mpos, mneg});
      end
      if (e[1]) begin
        mneg = mpos;
        mpos = mpos + 2'd1;
      end
      if (k < L + N + 2) @(negedge rclk);
    end
  endtask

  task automatic test_abort();
    logic [7:0] o, e;
    int L, N;
    L = 2;
    N = 4;
    bus.cfg_wr_lat = 3'd2;
    bus.burst_length_four = 1'b0;
    bus.cmd_rd = 1'b0;
    bus.cmd_valid = 1'b1;
    @(negedge rclk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      e = exp_vec(1'b0, L, N, k);
      o = obs_vec();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort_wr k=%0d got=%b exp=%b", k, o, e);
      end
      if (k < 4) @(negedge rclk);
    end
    rst = 1'b1;
    @(negedge rclk);
    rst = 1'b0;
    mpos = 2'd0;
    mneg = 2'd0;
    o = obs_vec();
    checks++;
    if (o !== 8'b0100_0000) begin
      failures++;
      $display("FAIL abort_idle got=%b exp=%b", o, 8'b0100_0000);
    end
    L = 2;
    N = 2;
    bus.cfg_cas_lat = 3'd2;
    bus.burst_length_four = 1'b1;
    bus.cmd_rd = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge rclk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= L + N + 2; k++) begin
      e = exp_vec(1'b1, L, N, k);
      o = obs_vec();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort_rd k=%0d got=%b exp=%b", k, o, e);
      end
      checks++;
      if ({bus.pad_pos_cnt, bus.pad_neg_cnt} !== {mpos, mneg}) begin
        failures++;
        $display("FAIL abort_rd_ptr k=%0d got=%b exp=%b", k,
                 {bus.pad_pos_cnt, bus.pad_neg_cnt}, {mpos, mneg});
      end
      if (e[1]) begin
        mneg = mpos;
        mpos = mpos + 2'd1;
      end
      if (k < L + N + 2) @(negedge rclk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mpos = 2'd0;
    mneg = 2'd0;
    rst = 1'b1;
    bus.cfg_cas_lat = 3'd2;
    bus.cfg_wr_lat = 3'd1;
    bus.burst_length_four = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rd = 1'b0;
    test_reset();
    test_write_wl1();
    test_read_cl3();
    test_clamp();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
